// File: rtl/sw_led_pkg.sv
// sw_led_pkg: shared constants and types for the switch/LED controller.
//   mode_t        - 2-bit display mode (MODE_PASS/BLINK/CHASE/COUNT)
//   DEF_*         - default parameter values
//   cnt_width()   - counter width helper for cycle-count parameters
package sw_led_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_CHASE = 2'b10,
        MODE_COUNT = 2'b11
    } mode_t;

    localparam int DEF_WIDTH           = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_BLINK_CYCLES    = 50_000_000;
    localparam int DEF_STEP_CYCLES     = 10_000_000;

    // Counter counts 0..n-1, so $clog2(n) bits always hold n-1; keep at least 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_led_ctrl_if.sv
// sw_led_ctrl_if: switch input / debounced output bundle.
//   sw      - raw switch levels (master drives)
//   sw_db   - debounced switch levels (slave drives)
//   sw_chg  - one-cycle change pulse (slave drives)
interface sw_led_ctrl_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_db;
    logic             sw_chg;

    modport master (output sw, input sw_db, input sw_chg);
    modport slave  (input sw, output sw_db, output sw_chg);

endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser, free-running sample counter and
// per-bit two-sample agreement debounce.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side: sw in, sw_db / sw_chg out
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic           clk,
    input logic           rst_n,
    sw_led_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_next;
    logic [CW-1:0]    sample_cnt;
    logic             sample_tick;
    logic             chg;

    assign sample_tick = (sample_cnt == SAMPLE_LAST);

    // A bit only moves when two consecutive samples agree; otherwise it holds.
    always_comb begin
        db_next = (~(sw_sync ^ prev) & sw_sync) | ((sw_sync ^ prev) & db);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            prev       <= '0;
            db         <= '0;
            sample_cnt <= '0;
            chg        <= 1'b0;
        end else begin
            sw_meta    <= bus.sw;
            sw_sync    <= sw_meta;
            chg        <= 1'b0;
            sample_cnt <= sample_tick ? '0 : sample_cnt + 1'b1;
            if (sample_tick) begin
                prev <= sw_sync;
                db   <= db_next;
                chg  <= |(db_next ^ db);
            end
        end
    end

    assign bus.sw_db  = db;
    assign bus.sw_chg = chg;

endmodule

// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: debounced switches driving LEDs in one of four display modes.
//   clk, rst_n - clock, asynchronous active-low reset
//   sw         - raw switch levels
//   mode       - display mode select (asynchronous)
//   led        - registered LED drive
//   sw_db      - debounced switch levels
//   sw_chg     - one-cycle pulse on any sw_db change
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int BLINK_CYCLES    = DEF_BLINK_CYCLES,
    parameter int STEP_CYCLES     = DEF_STEP_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_chg
);

    localparam int BW = cnt_width(BLINK_CYCLES);
    localparam int SW = cnt_width(STEP_CYCLES);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [SW-1:0]    STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE_HOT0   = {{(WIDTH-1){1'b0}}, 1'b1};

    sw_led_ctrl_if #(.WIDTH(WIDTH)) db_bus ();

    assign db_bus.sw = sw;
    assign sw_db     = db_bus.sw_db;
    assign sw_chg    = db_bus.sw_chg;

    sw_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (db_bus.slave)
    );

    logic [1:0]       mode_meta;
    logic [1:0]       mode_sync;
    mode_t            mode_q;
    logic             mode_chg;
    logic [BW-1:0]    blink_cnt;
    logic             phase;
    logic [SW-1:0]    step_cnt;
    logic             blink_tick;
    logic             step_tick;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] led_next;

    assign mode_chg   = (mode_sync != mode_q);
    assign blink_tick = (blink_cnt == BLINK_LAST);
    assign step_tick  = (step_cnt == STEP_LAST);

    // mode_chg is tested first everywhere so a restart wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta <= '0;
            mode_sync <= '0;
            mode_q    <= MODE_PASS;
            blink_cnt <= '0;
            phase     <= 1'b1;
            step_cnt  <= '0;
            pattern   <= ONE_HOT0;
            count     <= '0;
            led       <= '0;
        end else begin
            mode_meta <= mode;
            mode_sync <= mode_meta;
            mode_q    <= mode_t'(mode_sync);
            led       <= led_next;
            if (mode_chg) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
                step_cnt  <= '0;
                pattern   <= ONE_HOT0;
                count     <= '0;
            end else begin
                if (blink_tick) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
                if (step_tick) begin
                    step_cnt <= '0;
                    pattern  <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                    count    <= count + 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        led_next = '0;
        case (mode_q)
            MODE_PASS:  led_next = db_bus.sw_db;
            MODE_BLINK: led_next = phase ? db_bus.sw_db : '0;
            MODE_CHASE: led_next = (db_bus.sw_db == '0) ? pattern : (pattern & db_bus.sw_db);
            MODE_COUNT: led_next = count;
        endcase
    end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb_sw_led_ctrl: self-checking bench for sw_led_ctrl (WIDTH=8,
// DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, STEP_CYCLES=4). Expected LED values
// are queued when a mode is driven and popped once per cycle.
module tb_sw_led_ctrl;
    import sw_led_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] led;

    sw_led_ctrl_if #(.WIDTH(W)) bus ();

    sw_led_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8),
        .STEP_CYCLES     (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (bus.sw),
        .mode   (mode),
        .led    (led),
        .sw_db  (bus.sw_db),
        .sw_chg (bus.sw_chg)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int unsigned  t_drive;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_led(input logic [W-1:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    // Drive at a negedge; the new mode reaches led on the 4th rising edge.
    task automatic set_mode(input logic [1:0] m);
        mode    = m;
        t_drive = edge_cnt;
        cyc(4);
    endtask

    task automatic drain_led(input string tag);
        logic [W-1:0] v;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check(tag, led, v);
            if (exp_q.size() > 0) cyc(1);
        end
    endtask

    // Bounded wait for sw_db: 2 sample periods + 2 sync cycles + sampling slack.
    task automatic wait_db(input logic [W-1:0] exp, input string tag, output int pulses);
        int n;
        n      = 0;
        pulses = 0;
        while (bus.sw_db !== exp && n < 11) begin
            cyc(1);
            n++;
            if (bus.sw_chg) pulses++;
        end
        check(tag, bus.sw_db, exp);
    endtask

    task automatic check_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_led"}, led, '0);
            check({tag, "_db"}, bus.sw_db, '0);
            check({tag, "_chg"}, W'(bus.sw_chg), '0);
            cyc(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [W-1:0] led_before;

        // Reset with all switches high.
        bus.sw = 8'hFF;
        cyc(3);
        check("rst_led", led, '0);
        check("rst_db", bus.sw_db, '0);
        check("rst_chg", W'(bus.sw_chg), '0);
        bus.sw = 8'h00;
        rst_n  = 1'b1;
        check_quiet("post_rst", 20);

        // Debounce a steady change in PASS mode.
        bus.sw = 8'hA5;
        wait_db(8'hA5, "db_a5", pulses);
        led_before = led;
        check("led_lag", led_before, 8'h00);
        cyc(1);
        check("led_a5", led, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (bus.sw_chg) pulses++;
        end
        check("chg_once", W'(pulses), 8'd1);

        // Two-cycle glitch must not reach sw_db.
        pulses = 0;
        bus.sw = 8'h01;
        cyc(2);
        bus.sw = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("glitch_db", bus.sw_db, 8'hA5);
            if (bus.sw_chg) pulses++;
        end
        check("glitch_chg", W'(pulses), 8'd0);
        check("glitch_led", led, 8'hA5);

        // Blink.
        bus.sw = 8'h0F;
        wait_db(8'h0F, "db_0f", pulses);
        cyc(3);
        for (int i = 0; i < 2; i++) begin
            push_led(8'h0F, 8);
            push_led(8'h00, 8);
        end
        set_mode(MODE_BLINK);
        drain_led("blink");

        // Chase across all lanes, including the MSB wrap.
        bus.sw = 8'h00;
        wait_db(8'h00, "db_00", pulses);
        cyc(2);
        for (int k = 0; k < 10; k++) push_led(W'(1 << (k % 8)), 4);
        set_mode(MODE_CHASE);
        drain_led("chase_all");

        // Chase masked to lanes 0 and 1.
        cyc(1);
        mode   = MODE_PASS;
        bus.sw = 8'h03;
        wait_db(8'h03, "db_03", pulses);
        cyc(4);
        check("pass_03", led, 8'h03);
        push_led(8'h01, 4);
        push_led(8'h02, 4);
        push_led(8'h00, 24);
        push_led(8'h01, 4);
        push_led(8'h02, 4);
        set_mode(MODE_CHASE);
        drain_led("chase_mask");

        // Count through a full wrap.
        cyc(1);
        mode = MODE_PASS;
        cyc(6);
        for (int k = 0; k < 260; k++) push_led(W'(k % 256), 4);
        set_mode(MODE_COUNT);
        drain_led("count");

        // Mode changes landing on step-tick cycles: restart must win.
        while (((edge_cnt - t_drive) % 4) != 0) cyc(1);
        mode = MODE_PASS;
        cyc(4);
        push_led(8'h00, 4);
        push_led(8'h01, 4);
        push_led(8'h02, 4);
        set_mode(MODE_COUNT);
        drain_led("count_prio");

        // Asynchronous reset mid-operation.
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_led", led, '0);
        check("mid_rst_db", bus.sw_db, '0);
        check("mid_rst_chg", W'(bus.sw_chg), '0);
        mode   = MODE_PASS;
        bus.sw = 8'h00;
        cyc(2);
        rst_n = 1'b1;
        check_quiet("mid_post_rst", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_led_ctrl.md
SW_LED_CTRL -- requirements
Module: sw_led_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: number of switch inputs and LED outputs; legal range 2..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000: clock cycles between debounce samples (10 ms at 100 MHz).
REQ-003 Parameter BLINK_CYCLES, default 50_000_000: clock cycles per blink half-period.
REQ-004 Parameter STEP_CYCLES, default 10_000_000: clock cycles per chase/count step.
REQ-005 The port list SHALL be, in this order:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  WIDTH  raw asynchronous switch levels.
- mode  input  2  display mode select, asynchronous to clk.
- led  output  WIDTH  registered LED drive.
- sw_db  output  WIDTH  debounced switch levels.
- sw_chg  output  1  one-cycle pulse when any sw_db bit changes.

Function
REQ-006 sw and mode SHALL each pass through a two-flop synchroniser before use.
REQ-007 A sample counter SHALL count 0..DEBOUNCE_CYCLES-1 and wrap, asserting a sample tick on the cycle it equals DEBOUNCE_CYCLES-1.
REQ-008 On each sample tick the synchronised sw SHALL be captured into a previous-sample register.
REQ-009 On a sample tick, each sw_db bit SHALL take the new sample only when that bit equals the previous sample; otherwise it holds.
REQ-010 sw_chg SHALL be high for exactly the one cycle after any sw_db bit updates to a different value.
REQ-011 Glitches shorter than one sample period SHALL never reach sw_db.
REQ-012 A blink counter SHALL toggle a blink phase every BLINK_CYCLES cycles.
REQ-013 A step counter SHALL assert a step tick every STEP_CYCLES cycles.
REQ-014 Modes (decoded from synchronised mode):
- 2'b00 PASS: led = sw_db.
- 2'b01 BLINK: led = sw_db when phase = 1, else all zeros.
- 2'b10 CHASE: led = one-hot pattern that rotates left one bit per step tick; the MSB wraps to bit 0; active only in lanes where sw_db = 1, or across all lanes when sw_db is all zeros.
- 2'b11 COUNT: led = WIDTH-bit binary counter, +1 per step tick, wrapping modulo 2^WIDTH.
REQ-015 led SHALL be registered, with one cycle of latency from sw_db, phase or pattern to led.
REQ-016 When the synchronised mode value changes, the following SHALL all restart on the next cycle:
- chase pattern to 1;
- count to 0;
- blink phase to 1;
- blink and step counters to 0.
REQ-017 If a mode change and a step tick coincide, the mode-change restart SHALL take priority.
REQ-018 Counter widths SHALL be $clog2 of the respective cycle parameter, with no truncation at the maximum parameter values.

Reset
REQ-019 While rst_n = 0 the block SHALL immediately hold the following values:
- led = 0, sw_db = 0, sw_chg = 0;
- synchronisers and previous sample = 0;
- all counters = 0;
- blink phase = 1, chase pattern = 1;
- registered mode = PASS.
REQ-020 Reset deassertion mid-operation SHALL restart debounce from a zero history; no stale pulse SHALL appear on sw_chg.

Structure
REQ-021 Package sw_led_pkg SHALL hold the following:
- the 2-bit mode constants MODE_PASS, MODE_BLINK, MODE_CHASE and MODE_COUNT;
- the default cycle constants.
REQ-022 Synchroniser, sample counter and per-bit debounce SHALL form a sub-module sw_debounce (parameters WIDTH, DEBOUNCE_CYCLES).

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, STEP_CYCLES=4)
REQ-023 Reset: rst_n low with sw=8'hFF -> led=0, sw_db=0, sw_chg=0; hold for 20 cycles after release with sw=0 -> outputs stay 0.
REQ-024 Debounce: mode=PASS, sw 8'h00->8'hA5 held steady -> sw_db=8'hA5 within 2 sample ticks plus 2 sync cycles, single sw_chg pulse, led=8'hA5 one cycle later; a 2-cycle pulse sw=8'h01 -> sw_db unchanged, no sw_chg.
REQ-025 Blink: sw_db=8'h0F, mode=BLINK -> led alternates 8'h0F / 8'h00 every 8 cycles, starting with 8'h0F after the mode change.
REQ-026 Chase: sw_db=0, mode=CHASE -> led 8'h01,02,04,...,80,01 at 4-cycle steps (wrap checked); with sw_db=8'h03 -> led shows only 8'h01 and 8'h02 lanes.
REQ-027 Count/priority: mode=COUNT runs 256 steps -> led wraps 8'hFF->8'h00; mode switched to PASS and back to COUNT on a step-tick cycle -> led restarts at 8'h00.
